casex_match_stage: RTL and testbench
====================================

Name: casex_match_stage

Overview:
- Pipelined masked-pattern classifier that sits directly upstream of result consumers.
- Forms key = val1 & val2 and matches it against a programmable table of wildcard patterns, using priority casex semantics.
- The winning entry either loads a result value or is a null action, which holds the previous result.
- Valid/ready handshake on both the input and output sides; table is written through a config port.

Parameters:
- WIDTH, 3, operand/key width.
- NPAT, 4, number of pattern entries.
- IDXW, 2, entry index width (2^IDXW >= NPAT).
- RW, 3, result width.
- DEFAULT_RESULT, 0, no-match result; used only with CASEX_DEFAULT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept an operand pair.
- val1  in  WIDTH  operand A.
- val2  in  WIDTH  operand B.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDXW  entry written.
- cfg_value  in  WIDTH  pattern bits.
- cfg_care  in  WIDTH  1 = bit compared, 0 = don't-care.
- cfg_result  in  RW  value loaded on hit.
- cfg_act  in  1  1 = load cfg_result, 0 = null action (hold).
- out_valid  out  1  classification valid.
- out_ready  in  1  downstream accepts.
- result  out  RW  current result.
- hit  out  1  some entry matched.
- hit_idx  out  IDXW  winning entry (0 when hit=0).
- miss_cnt  out  8  saturating no-match count.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All entries invalid; pipeline empty.
  - result=0, hit=0, hit_idx=0, out_valid=0, miss_cnt=0.
  - in_ready=0 while rst_n=0.
- Stage S1: on in_valid&&in_ready, register key = val1 & val2 and set s1_valid.
- Stage S2 (output register): when S1 is valid and S2 is empty or being drained (out_valid&&out_ready), match S1 key and update the outputs.
  - Latency: 2 cycles from accept to out_valid when not stalled.
- in_ready = !s1_valid || S1 advances this cycle. Full throughput of 1 key/cycle when out_ready=1.
- Match rule: entry i hits iff entry valid && ((key ^ value_i) & care_i) == 0.
  - Lowest index wins; later overlapping entries are unreachable for those keys.
  - care_i = 0 matches every key.
- On hit:
  - hit=1, hit_idx=i.
  - act_i=1: result <= result_i.
  - act_i=0: result unchanged (null statement).
- On no match: hit=0, hit_idx=0, result unchanged, miss_cnt += 1, saturating at 255.
- Stall: while out_valid && !out_ready, all S2 outputs are frozen. S1 fills, then in_ready=0. No key is dropped or duplicated; order is preserved.
- result is a held value: it persists across out_valid deassertion and updates only on S2 load.
- Config writes:
  - cfg_we at a posedge writes the entry and marks it valid.
  - A key matched in the same cycle uses the old table contents.
  - A cfg_idx >= NPAT is ignored.
- Reset mid-operation drops in-flight keys and returns every output to its reset value.

Optional Feature:
- Macro CASEX_DEFAULT_EN.
- Defined: a no-match loads result <= DEFAULT_RESULT (default branch semantics); miss_cnt still increments.
- Undefined: a no-match holds result (no default branch).
- Null-action hits hold result in both builds.

Test Plan:
- Setup: after reset, program entry0 value=000 care=110 result=0 act=1; entry1 value=100 care=110 act=0; entry2 value=001 care=111 result=1 act=1.
  - Drive val1=000, val2=000 with out_ready=1 -> 2 cycles later out_valid=1, result=0, hit=1, hit_idx=0.
- Priority: val1=001, val2=011 (key 001) -> entry0 wins over entry2: result=0, hit_idx=0. Reprogram entry0 care=111 value=000, resend -> result=1, hit_idx=2.
- Null action: result=1, then val1=111, val2=101 (key 101) -> hit=1, hit_idx=1, result stays 1.
- No match: val1=111, val2=010 (key 010) -> hit=0, result stays 1, miss_cnt=1. With CASEX_DEFAULT_EN and DEFAULT_RESULT=5 -> result=5.
- Backpressure: stream keys 000, 001, 101 with out_ready=0 for 3 cycles.
  - in_ready drops after S1 fills; outputs stay frozen.
  - After release, results appear in order with no loss.
- Saturation/reset: 300 unmatched keys -> miss_cnt=255. Assert rst_n=0 for one cycle mid-stream -> all outputs 0, table invalid, next key gives hit=0.

Source files
------------

// File: rtl/casex_match_stage.sv
// Two-stage masked-pattern classifier: S1 registers key = val1 & val2, S2 matches it
// against a priority wildcard table. Optional macro CASEX_DEFAULT_EN loads DEFAULT_RESULT on a miss.
module casex_match_stage #(
  parameter int unsigned     WIDTH          = 3,
  parameter int unsigned     NPAT           = 4,
  parameter int unsigned     IDXW           = 2,
  parameter int unsigned     RW             = 3,
  parameter logic [RW-1:0]   DEFAULT_RESULT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  val1,
  input  logic [WIDTH-1:0]  val2,
  input  logic              cfg_we,
  input  logic [IDXW-1:0]   cfg_idx,
  input  logic [WIDTH-1:0]  cfg_value,
  input  logic [WIDTH-1:0]  cfg_care,
  input  logic [RW-1:0]     cfg_result,
  input  logic              cfg_act,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     result,
  output logic              hit,
  output logic [IDXW-1:0]   hit_idx,
  output logic [7:0]        miss_cnt
);

`ifdef CASEX_DEFAULT_EN
  localparam bit NOMATCH_LOAD = 1'b1;
`else
  localparam bit NOMATCH_LOAD = 1'b0;
`endif

  logic [NPAT-1:0]  tvalid;
  logic [WIDTH-1:0] tvalue  [NPAT];
  logic [WIDTH-1:0] tcare   [NPAT];
  logic [RW-1:0]    tresult [NPAT];
  logic             tact    [NPAT];

  logic             s1_valid;
  logic [WIDTH-1:0] s1_key;
  logic             s2_load;
  logic             cfg_ok;
  logic             m_hit;
  logic [IDXW-1:0]  m_idx;

  assign cfg_ok   = cfg_we && (32'(cfg_idx) < NPAT);
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = rst_n && (!s1_valid || s2_load);

  // Table valid bits are the only table state that needs reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tvalid <= '0;
    end else if (cfg_ok) begin
      tvalid[cfg_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      tvalue[cfg_idx]  <= cfg_value;
      tcare[cfg_idx]   <= cfg_care;
      tresult[cfg_idx] <= cfg_result;
      tact[cfg_idx]    <= cfg_act;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_key   <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_key   <= val1 & val2;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Priority match: the first hit latches, so lower indices shadow later overlaps.
  always_comb begin
    m_hit = 1'b0;
    m_idx = '0;
    for (int unsigned i = 0; i < NPAT; i++) begin
      if (!m_hit && tvalid[i] && (((s1_key ^ tvalue[i]) & tcare[i]) == '0)) begin
        m_hit = 1'b1;
        m_idx = IDXW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      miss_cnt  <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      hit       <= m_hit;
      hit_idx   <= m_idx;
      if (m_hit) begin
        if (tact[m_idx]) begin
          result <= tresult[m_idx];
        end
      end else begin
        if (NOMATCH_LOAD) begin
          result <= DEFAULT_RESULT;
        end
        if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + 8'd1;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_casex_match_stage.sv
// Directed bench for casex_match_stage: table programming, priority, null action,
// misses, backpressure, miss saturation and mid-stream reset.
module tb_casex_match_stage;

`ifdef CASEX_DEFAULT_EN
  localparam bit DEF_EN = 1'b1;
`else
  localparam bit DEF_EN = 1'b0;
`endif
  localparam logic [2:0] DEFRES = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] val1, val2;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [2:0] cfg_value, cfg_care, cfg_result;
  logic       cfg_act;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] result;
  logic       hit;
  logic [1:0] hit_idx;
  logic [7:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  logic [2:0] miss_res;

  casex_match_stage #(
    .WIDTH(3), .NPAT(4), .IDXW(2), .RW(3), .DEFAULT_RESULT(DEFRES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .val1(val1), .val2(val2), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_value(cfg_value), .cfg_care(cfg_care), .cfg_result(cfg_result),
    .cfg_act(cfg_act), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .hit(hit), .hit_idx(hit_idx), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [2:0] res,
                         input logic h, input logic [1:0] idx);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".result"},    32'(result),    32'(res));
    chk({tag, ".hit"},       32'(hit),       32'(h));
    chk({tag, ".hit_idx"},   32'(hit_idx),   32'(idx));
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [2:0] v, input logic [2:0] c,
                     input logic [2:0] r, input logic a);
    cfg_we = 1'b1; cfg_idx = idx; cfg_value = v; cfg_care = c; cfg_result = r; cfg_act = a;
    tick();
    cfg_we = 1'b0;
  endtask

  // Accept at the first edge, S2 loads at the second: out_valid two cycles after accept.
  task automatic send(input logic [2:0] a, input logic [2:0] b);
    in_valid = 1'b1; val1 = a; val2 = b;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    miss_res = DEF_EN ? DEFRES : 3'd1;
    rst_n = 1'b0; in_valid = 1'b0; val1 = '0; val2 = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_value = '0; cfg_care = '0; cfg_result = '0; cfg_act = 1'b0;
    tick();
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk_out("rst", 1'b0, 3'd0, 1'b0, 2'd0);
    chk("rst.miss_cnt", 32'(miss_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready_rel", 32'(in_ready), 32'd1);

    cfg(2'd0, 3'b000, 3'b110, 3'd0, 1'b1);
    cfg(2'd1, 3'b100, 3'b110, 3'd0, 1'b0);
    cfg(2'd2, 3'b001, 3'b111, 3'd1, 1'b1);

    send(3'b000, 3'b000);
    chk_out("basic", 1'b1, 3'd0, 1'b1, 2'd0);
    send(3'b001, 3'b011);
    chk_out("prio0", 1'b1, 3'd0, 1'b1, 2'd0);
    cfg(2'd0, 3'b000, 3'b111, 3'd0, 1'b1);
    send(3'b001, 3'b011);
    chk_out("prio2", 1'b1, 3'd1, 1'b1, 2'd2);
    send(3'b111, 3'b101);
    chk_out("null", 1'b1, 3'd1, 1'b1, 2'd1);
    send(3'b111, 3'b010);
    chk_out("miss", 1'b1, miss_res, 1'b0, 2'd0);
    chk("miss.cnt", 32'(miss_cnt), 32'd1);

    // Key 010 sits in S1 while entry3 (matching 010) is written on the S2 load edge.
    in_valid = 1'b1; val1 = 3'b010; val2 = 3'b111;
    tick();
    in_valid = 1'b0;
    cfg(2'd3, 3'b010, 3'b111, 3'd6, 1'b1);
    chk_out("samecyc", 1'b1, miss_res, 1'b0, 2'd0);
    chk("samecyc.cnt", 32'(miss_cnt), 32'd2);
    send(3'b010, 3'b111);
    chk_out("newentry", 1'b1, 3'd6, 1'b1, 2'd3);

    out_ready = 1'b0;
    in_valid = 1'b1; val1 = 3'b000; val2 = 3'b111;
    tick();
    val1 = 3'b001;
    chk("bp.in_ready0", 32'(in_ready), 32'd0);
    chk_out("bp.frz1", 1'b1, 3'd6, 1'b1, 2'd3);
    tick();
    chk_out("bp.frz2", 1'b1, 3'd6, 1'b1, 2'd3);
    tick();
    chk_out("bp.frz3", 1'b1, 3'd6, 1'b1, 2'd3);
    chk("bp.in_ready1", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready2", 32'(in_ready), 32'd1);
    tick();
    val1 = 3'b101;
    chk_out("bp.k000", 1'b1, 3'd0, 1'b1, 2'd0);
    tick();
    in_valid = 1'b0;
    chk_out("bp.k001", 1'b1, 3'd1, 1'b1, 2'd2);
    tick();
    chk_out("bp.k101", 1'b1, 3'd1, 1'b1, 2'd1);
    tick();
    chk("bp.drain", 32'(out_valid), 32'd0);
    chk("bp.cnt", 32'(miss_cnt), 32'd2);

    in_valid = 1'b1; val1 = 3'b011; val2 = 3'b011;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat.cnt", 32'(miss_cnt), 32'd255);
    chk_out("sat", 1'b0, miss_res, 1'b0, 2'd0);

    in_valid = 1'b1; val1 = 3'b000; val2 = 3'b000;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("mrst", 1'b0, 3'd0, 1'b0, 2'd0);
    chk("mrst.cnt", 32'(miss_cnt), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("mrst.flushed", 32'(out_valid), 32'd0);
    send(3'b000, 3'b000);
    chk_out("post", 1'b1, DEF_EN ? DEFRES : 3'd0, 1'b0, 2'd0);
    chk("post.cnt", 32'(miss_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
